// File: rtl/utils_pkg.sv
// Shared AXI4 typedefs, response/burst constants and burst address helper,
// used by the memory slave model and the DMA.
package utils_pkg;

  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_ID_WIDTH   = 4;
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef logic [AXI_DATA_WIDTH-1:0] axi_data_t;
  typedef logic [AXI_ADDR_WIDTH-1:0] axi_addr_t;
  typedef logic [AXI_ID_WIDTH-1:0]   axi_id_t;
  typedef logic [AXI_STRB_WIDTH-1:0] axi_strb_t;
  typedef logic [7:0]                axi_len_t;
  typedef logic [2:0]                axi_size_t;
  typedef logic [1:0]                axi_burst_t;
  typedef logic [1:0]                axi_resp_t;

  localparam axi_resp_t  AXI_OKAY        = 2'b00;
  localparam axi_resp_t  AXI_SLVERR      = 2'b10;
  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
  localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
  localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

  typedef struct packed {
    axi_id_t    awid;
    axi_addr_t  awaddr;
    axi_len_t   awlen;
    axi_size_t  awsize;
    axi_burst_t awburst;
    logic       awvalid;
    axi_data_t  wdata;
    axi_strb_t  wstrb;
    logic       wlast;
    logic       wvalid;
    logic       bready;
    axi_id_t    arid;
    axi_addr_t  araddr;
    axi_len_t   arlen;
    axi_size_t  arsize;
    axi_burst_t arburst;
    logic       arvalid;
    logic       rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic      awready;
    logic      wready;
    axi_id_t   bid;
    axi_resp_t bresp;
    logic      bvalid;
    logic      arready;
    axi_id_t   rid;
    axi_data_t rdata;
    axi_resp_t rresp;
    logic      rlast;
    logic      rvalid;
  } s_axi_miso_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} axi_mem_wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} axi_mem_rd_state_e;

  // FIXED holds the address; everything else steps by the transfer size.
  function automatic axi_addr_t axi_burst_next_addr(input axi_addr_t addr,
                                                    input axi_size_t size,
                                                    input axi_burst_t burst);
    if (burst == AXI_BURST_FIXED) return addr;
    return addr + (axi_addr_t'(1) << size);
  endfunction

endpackage

// File: rtl/axi_mem_slave_ram.sv
// Word array with a combinational read port and a byte-enabled write port.
module axi_mem_slave_ram
  import utils_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx_i,
  output axi_data_t        rd_data_c,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  axi_strb_t        wr_strb_i,
  input  axi_data_t        wr_data_i
);

  axi_data_t mem_q [MEM_WORDS];

  assign rd_data_c = mem_q[rd_idx_i];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < int'(AXI_STRB_WIDTH); b++) begin
        if (wr_strb_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: independent single-outstanding read and write engines
// over an internal word array, with optional read wait states.
module axi_mem_slave
  import utils_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter axi_addr_t   BASE_ADDR = '0,
  parameter int unsigned RD_WAIT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);

  localparam int unsigned NB     = AXI_DATA_WIDTH / 8;
  localparam int unsigned NB_LOG = $clog2(NB);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned AW1    = AXI_ADDR_WIDTH + 1;
  localparam int unsigned RW_W   = 4;
  localparam logic [AW1-1:0] SPAN = AW1'(MEM_WORDS) * AW1'(NB);

  function automatic logic in_range(input axi_addr_t a);
    logic [AW1-1:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a >= BASE_ADDR) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input axi_addr_t a);
    axi_addr_t off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> NB_LOG);
  endfunction

  function automatic logic req_bad(input axi_size_t size, input axi_burst_t burst);
    return (size > axi_size_t'(NB_LOG)) ||
           ((burst != AXI_BURST_FIXED) && (burst != AXI_BURST_INCR));
  endfunction

  // Write engine state
  axi_mem_wr_state_e w_state_q, w_state_d;
  axi_id_t    awid_q, awid_d;
  axi_addr_t  waddr_q, waddr_d;
  axi_len_t   awlen_q, awlen_d, wcnt_q, wcnt_d;
  axi_size_t  awsize_q, awsize_d;
  axi_burst_t awburst_q, awburst_d;
  logic       werr_q, werr_d;
  logic       awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  axi_resp_t  bresp_q, bresp_d;
  logic       mem_we_c;
  logic       wbeat_last_c;

  // Read engine state
  axi_mem_rd_state_e r_state_q, r_state_d;
  axi_id_t    arid_q, arid_d;
  axi_addr_t  raddr_q, raddr_d;
  axi_len_t   arlen_q, arlen_d, rcnt_q, rcnt_d;
  axi_size_t  arsize_q, arsize_d;
  axi_burst_t arburst_q, arburst_d;
  logic       rerr_q, rerr_d;
  logic [RW_W-1:0] rwait_q, rwait_d;
  logic       arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  axi_data_t  rdata_q, rdata_d;
  axi_resp_t  rresp_q, rresp_d;
  axi_addr_t  rd_addr_c;
  axi_data_t  ram_rdata_c;
  logic       rbeat_bad_c;

  axi_mem_slave_ram #(.MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)) u_ram (
    .clk       (clk),
    .rd_idx_i  (word_idx(rd_addr_c)),
    .rd_data_c (ram_rdata_c),
    .we_i      (mem_we_c),
    .wr_idx_i  (word_idx(waddr_q)),
    .wr_strb_i (axi_mosi_i.wstrb),
    .wr_data_i (axi_mosi_i.wdata)
  );

  always_comb begin
    w_state_d    = w_state_q;
    awid_d       = awid_q;
    waddr_d      = waddr_q;
    awlen_d      = awlen_q;
    awsize_d     = awsize_q;
    awburst_d    = awburst_q;
    wcnt_d       = wcnt_q;
    werr_d       = werr_q;
    bresp_d      = bresp_q;
    mem_we_c     = 1'b0;
    wbeat_last_c = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (axi_mosi_i.awvalid && awready_q) begin
          awid_d    = axi_mosi_i.awid;
          waddr_d   = axi_mosi_i.awaddr;
          awlen_d   = axi_mosi_i.awlen;
          awsize_d  = axi_mosi_i.awsize;
          awburst_d = axi_mosi_i.awburst;
          wcnt_d    = '0;
          werr_d    = !in_range(axi_mosi_i.awaddr) ||
                      req_bad(axi_mosi_i.awsize, axi_mosi_i.awburst);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axi_mosi_i.wvalid && wready_q) begin
          wbeat_last_c = axi_mosi_i.wlast || (wcnt_q == awlen_q);
          mem_we_c     = !werr_q && in_range(waddr_q);
          if (!in_range(waddr_q)) werr_d = 1'b1;
          if (axi_mosi_i.wlast != (wcnt_q == awlen_q)) werr_d = 1'b1;
          waddr_d = axi_burst_next_addr(waddr_q, awsize_q, awburst_q);
          if (wbeat_last_c) begin
            w_state_d = W_RESP;
            bresp_d   = werr_d ? AXI_SLVERR : AXI_OKAY;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (axi_mosi_i.bready && bvalid_q) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Address of the beat to prefetch into rdata on the coming edge.
  always_comb begin
    case (r_state_q)
      R_IDLE:  rd_addr_c = axi_mosi_i.araddr;
      R_DATA:  rd_addr_c = axi_burst_next_addr(raddr_q, arsize_q, arburst_q);
      default: rd_addr_c = raddr_q;
    endcase
  end

  always_comb begin
    r_state_d   = r_state_q;
    arid_d      = arid_q;
    raddr_d     = raddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    rcnt_d      = rcnt_q;
    rerr_d      = rerr_q;
    rwait_d     = rwait_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    rbeat_bad_c = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (axi_mosi_i.arvalid && arready_q) begin
          arid_d    = axi_mosi_i.arid;
          raddr_d   = axi_mosi_i.araddr;
          arlen_d   = axi_mosi_i.arlen;
          arsize_d  = axi_mosi_i.arsize;
          arburst_d = axi_mosi_i.arburst;
          rcnt_d    = '0;
          rerr_d    = !in_range(axi_mosi_i.araddr) ||
                      req_bad(axi_mosi_i.arsize, axi_mosi_i.arburst);
          if (RD_WAIT == 0) begin
            r_state_d   = R_DATA;
            rbeat_bad_c = rerr_d || !in_range(rd_addr_c);
            rdata_d     = rbeat_bad_c ? '0 : ram_rdata_c;
            rresp_d     = rbeat_bad_c ? AXI_SLVERR : AXI_OKAY;
            rlast_d     = (axi_mosi_i.arlen == '0);
          end else begin
            r_state_d = R_WAIT;
            rwait_d   = RW_W'(RD_WAIT);
          end
        end
      end
      R_WAIT: begin
        if (rwait_q == '0) begin
          r_state_d   = R_DATA;
          rbeat_bad_c = rerr_q || !in_range(rd_addr_c);
          rdata_d     = rbeat_bad_c ? '0 : ram_rdata_c;
          rresp_d     = rbeat_bad_c ? AXI_SLVERR : AXI_OKAY;
          rlast_d     = (arlen_q == '0);
        end else begin
          rwait_d = rwait_q - RW_W'(1);
        end
      end
      R_DATA: begin
        if (axi_mosi_i.rready) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rdata_d   = '0;
            rresp_d   = AXI_OKAY;
            rlast_d   = 1'b0;
          end else begin
            raddr_d     = rd_addr_c;
            rcnt_d      = rcnt_q + 8'd1;
            rbeat_bad_c = rerr_q || !in_range(rd_addr_c);
            rdata_d     = rbeat_bad_c ? '0 : ram_rdata_c;
            rresp_d     = rbeat_bad_c ? AXI_SLVERR : AXI_OKAY;
            rlast_d     = (rcnt_d == arlen_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      arid_q    <= '0;
      raddr_q   <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      rcnt_q    <= '0;
      rerr_q    <= 1'b0;
      rwait_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arid_q    <= arid_d;
      raddr_q   <= raddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      rcnt_q    <= rcnt_d;
      rerr_q    <= rerr_d;
      rwait_q   <= rwait_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    axi_miso_o         = '0;
    axi_miso_o.awready = awready_q;
    axi_miso_o.wready  = wready_q;
    axi_miso_o.bid     = awid_q;
    axi_miso_o.bresp   = bresp_q;
    axi_miso_o.bvalid  = bvalid_q;
    axi_miso_o.arready = arready_q;
    axi_miso_o.rid     = arid_q;
    axi_miso_o.rdata   = rdata_q;
    axi_miso_o.rresp   = rresp_q;
    axi_miso_o.rlast   = rlast_q;
    axi_miso_o.rvalid  = rvalid_q;
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: transaction table plus hand sequences for
// read wait states, backpressure and reset in the middle of a burst.
module tb_axi_mem_slave;
  import utils_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  int n_cmp = 0;
  int n_fail = 0;

  s_axi_mosi_t m, mosi0, mosi3;
  s_axi_miso_t miso0, miso3, s;

  always #5 clk = ~clk;

  // sel steers the single bench master onto either instance.
  always_comb begin
    mosi0 = sel ? '0 : m;
    mosi3 = sel ? m : '0;
    s     = sel ? miso3 : miso0;
  end

  axi_mem_slave #(.MEM_WORDS(1024), .BASE_ADDR('0), .RD_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .axi_mosi_i(mosi0), .axi_miso_o(miso0));
  axi_mem_slave #(.MEM_WORDS(1024), .BASE_ADDR('0), .RD_WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .axi_mosi_i(mosi3), .axi_miso_o(miso3));

  typedef struct {
    logic            wr;
    axi_addr_t       addr;
    axi_len_t        len;
    axi_size_t       size;
    axi_burst_t      burst;
    axi_id_t         id;
    int              last_at;
    logic [7:0][31:0] data;
    logic [7:0][3:0]  strb;
    logic [7:0][1:0]  resp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wr, input axi_addr_t a, input axi_len_t len,
                              input axi_burst_t b, input axi_id_t id,
                              input logic [31:0] d0, input logic [31:0] dstep,
                              input axi_resp_t r);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = len; v.size = 3'd2; v.burst = b; v.id = id;
    v.last_at = int'(len);
    for (int i = 0; i < 8; i++) begin
      v.data[i] = d0 + 32'(i) * dstep;
      v.strb[i] = 4'hF;
      v.resp[i] = r;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no handshake within 50 cycles, required one", name);
  endtask

  task automatic do_write(input vec_t v, input int bdelay);
    int t;
    @(negedge clk);
    m.awvalid = 1'b1; m.awid = v.id; m.awaddr = v.addr; m.awlen = v.len;
    m.awsize = v.size; m.awburst = v.burst;
    t = 0;
    while (!s.awready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin timeout("aw_accept"); m.awvalid = 1'b0; return; end
    @(negedge clk);
    m.awvalid = 1'b0;
    for (int i = 0; i <= v.last_at; i++) begin
      m.wvalid = 1'b1; m.wdata = v.data[i]; m.wstrb = v.strb[i]; m.wlast = (i == v.last_at);
      t = 0;
      while (!s.wready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin timeout("w_accept"); m.wvalid = 1'b0; m.wlast = 1'b0; return; end
      @(negedge clk);
    end
    m.wvalid = 1'b0; m.wlast = 1'b0;
    t = 0;
    while (!s.bvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin timeout("b_valid"); return; end
    for (int k = 0; k < bdelay; k++) begin
      check("bvalid_hold", 64'(s.bvalid), 64'(1));
      @(negedge clk);
    end
    check("bresp", 64'(s.bresp), 64'(v.resp[0]));
    check("bid", 64'(s.bid), 64'(v.id));
    m.bready = 1'b1;
    @(negedge clk);
    m.bready = 1'b0;
    check("bvalid_drop", 64'(s.bvalid), 64'(0));
  endtask

  task automatic do_read(input vec_t v);
    int t;
    @(negedge clk);
    m.arvalid = 1'b1; m.arid = v.id; m.araddr = v.addr; m.arlen = v.len;
    m.arsize = v.size; m.arburst = v.burst;
    t = 0;
    while (!s.arready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin timeout("ar_accept"); m.arvalid = 1'b0; return; end
    @(negedge clk);
    m.arvalid = 1'b0;
    m.rready = 1'b1;
    for (int i = 0; i <= int'(v.len); i++) begin
      t = 0;
      while (!s.rvalid && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin timeout("r_valid"); m.rready = 1'b0; return; end
      if (i > 0) check("beat_gap", 64'(t), 64'(0));
      check("rdata", 64'(s.rdata), 64'(v.data[i]));
      check("rresp", 64'(s.rresp), 64'(v.resp[i]));
      check("rlast", 64'(s.rlast), 64'(i == int'(v.len)));
      check("rid", 64'(s.rid), 64'(v.id));
      @(negedge clk);
    end
    m.rready = 1'b0;
    check("rvalid_drop", 64'(s.rvalid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int n;
    m = '0; sel = 1'b0; rst = 1'b0;

    tbl.push_back(mk(1, 'h10, 0, AXI_BURST_INCR, 3, 32'hDEADBEEF, 0, AXI_OKAY));
    tbl.push_back(mk(0, 'h10, 0, AXI_BURST_INCR, 3, 32'hDEADBEEF, 0, AXI_OKAY));
    tbl.push_back(mk(1, 'h100, 7, AXI_BURST_INCR, 1, 0, 1, AXI_OKAY));
    tbl.push_back(mk(0, 'h100, 7, AXI_BURST_INCR, 2, 0, 1, AXI_OKAY));
    tbl.push_back(mk(1, 'h20, 0, AXI_BURST_INCR, 0, 32'hAABBCCDD, 0, AXI_OKAY));
    v = mk(1, 'h20, 1, AXI_BURST_FIXED, 4, 32'h11111111, 32'h11111111, AXI_OKAY);
    v.strb[0] = 4'h1; v.strb[1] = 4'h8;
    tbl.push_back(v);
    tbl.push_back(mk(0, 'h20, 0, AXI_BURST_INCR, 5, 32'h22BBCC11, 0, AXI_OKAY));
    tbl.push_back(mk(1, 'h0, 0, AXI_BURST_INCR, 6, 32'hCAFEF00D, 0, AXI_OKAY));
    tbl.push_back(mk(1, 'h1000, 0, AXI_BURST_INCR, 7, 32'h12345678, 0, AXI_SLVERR));
    tbl.push_back(mk(0, 'h0, 0, AXI_BURST_INCR, 8, 32'hCAFEF00D, 0, AXI_OKAY));
    tbl.push_back(mk(1, 'hFFC, 0, AXI_BURST_INCR, 9, 32'h0BADF00D, 0, AXI_OKAY));
    v = mk(0, 'hFFC, 1, AXI_BURST_INCR, 10, 32'h0BADF00D, 0, AXI_OKAY);
    v.data[1] = '0; v.resp[1] = AXI_SLVERR;
    tbl.push_back(v);
    tbl.push_back(mk(1, 'h30, 1, AXI_BURST_WRAP, 11, 1, 1, AXI_SLVERR));
    tbl.push_back(mk(0, 'h10, 1, AXI_BURST_WRAP, 12, 0, 0, AXI_SLVERR));
    v = mk(1, 'h40, 0, AXI_BURST_INCR, 13, 32'h99, 0, AXI_SLVERR);
    v.size = 3'd3;
    tbl.push_back(v);
    v = mk(1, 'h50, 1, AXI_BURST_INCR, 14, 1, 1, AXI_SLVERR);
    v.last_at = 0;
    tbl.push_back(v);
    tbl.push_back(mk(0, 'h1000, 0, AXI_BURST_INCR, 15, 0, 0, AXI_SLVERR));

    // Reset values, then ready after release
    repeat (3) @(negedge clk);
    check("reset_miso0", 64'(miso0), 64'(0));
    check("reset_miso3", 64'(miso3), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    check("awready_after_reset", 64'(s.awready), 64'(1));
    check("arready_after_reset", 64'(s.arready), 64'(1));

    foreach (tbl[i]) begin
      if (tbl[i].wr) do_write(tbl[i], 0);
      else           do_read(tbl[i]);
    end

    // Wait states and backpressure on the RD_WAIT=3 instance
    sel = 1'b1;
    do_write(mk(1, 'h40, 1, AXI_BURST_INCR, 2, 32'h5A5A0000, 1, AXI_OKAY), 5);
    @(negedge clk);
    m.arvalid = 1'b1; m.arid = 4'd6; m.araddr = 'h40; m.arlen = 8'd1;
    m.arsize = 3'd2; m.arburst = AXI_BURST_INCR;
    check("arready_wait_inst", 64'(s.arready), 64'(1));
    @(posedge clk);
    #1 m.arvalid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); n++;
      #1;
      if (s.rvalid) break;
    end
    check("rd_wait_latency", 64'(n), 64'(4));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stall_rdata0", 64'(s.rdata), 64'(32'h5A5A0000));
      check("stall_rlast0", 64'(s.rlast), 64'(0));
    end
    m.rready = 1'b1;
    @(negedge clk);
    m.rready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("stall_rdata1", 64'(s.rdata), 64'(32'h5A5A0001));
      check("stall_rlast1", 64'(s.rlast), 64'(1));
      check("stall_rvalid1", 64'(s.rvalid), 64'(1));
      @(negedge clk);
    end
    m.rready = 1'b1;
    @(negedge clk);
    m.rready = 1'b0;
    check("rvalid_drop_wait", 64'(s.rvalid), 64'(0));
    sel = 1'b0;

    // Reset asserted after two beats of an eight-beat write
    @(negedge clk);
    m.awvalid = 1'b1; m.awid = 4'd1; m.awaddr = 'h200; m.awlen = 8'd7;
    m.awsize = 3'd2; m.awburst = AXI_BURST_INCR;
    check("awready_pre_burst", 64'(s.awready), 64'(1));
    @(negedge clk);
    m.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m.wvalid = 1'b1; m.wdata = 32'h70 + 32'(i); m.wstrb = 4'hF; m.wlast = 1'b0;
      check("wready_mid_burst", 64'(s.wready), 64'(1));
      @(negedge clk);
    end
    m = '0;
    rst = 1'b0;
    #1;
    check("midreset_miso0", 64'(miso0), 64'(0));
    check("midreset_miso3", 64'(miso3), 64'(0));
    repeat (2) @(negedge clk);
    check("midreset_hold", 64'(miso0), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    check("awready_post_reset", 64'(s.awready), 64'(1));
    check("bvalid_post_reset", 64'(s.bvalid), 64'(0));
    do_read(mk(0, 'h200, 1, AXI_BURST_INCR, 3, 32'h70, 1, AXI_OKAY));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
